ram16k_arbiter: RTL

Two-port arbiter that shares one single-port 16K x 16 RAM (combinational read, write on rising clock edge when `load` is high) between two independent requesters, e.g. the CPU data port and a screen/DMA engine. Each requester presents a command with a request/acknowledge handshake. The arbiter picks a winner, latches that command, drives the RAM for exactly one cycle, and then returns read data with a one-cycle acknowledge. The block sits between the requesters and the RAM16K instance; nothing else drives the RAM ports.

---
 rtl/ram16k_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ram16k_arbiter.sv
// ram16k_arbiter
// Shares one single-port 16K x 16 RAM (combinational read, write on the
// rising edge when load is high) between two requesters. A winner's command
// is latched, driven onto the RAM for one ACCESS cycle, and completed with a
// one-cycle ack in the following ACK cycle.
//
// Ports:
//   clock             system clock, rising edge active
//   reset             asynchronous active-low reset
//   req0/req1         request, held until the matching ack
//   we0/we1           1 = write, 0 = read
//   addr0/addr1       word address
//   wdata0/wdata1     write data
//   ack0/ack1         one-cycle completion pulse
//   rdata0/rdata1     read data, held until that port's next read completes
//   busy              high while the RAM is being accessed
//   ram_address       to RAM address
//   ram_in            to RAM data in
//   ram_load          to RAM write enable
//   ram_out           from RAM data out
module ram16k_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              win_q, win_d;       // 0 = port 0, 1 = port 1
  logic              last_q, last_d;     // port granted most recently
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic elig0, elig1, grant_sel;

  // State and datapath registers. Last-grant resets to port 1 so that
  // port 0 wins the first round-robin tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state logic. Arbitration happens in IDLE and in ACK; in ACK the
  // port being acknowledged is masked so a requester that keeps req high
  // cannot be re-granted before it has seen its ack.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    elig0     = 1'b0;
    elig1     = 1'b0;
    grant_sel = 1'b0;

    case (state_q)
      ST_IDLE: begin
        elig0 = req0;
        elig1 = req1;
      end
      ST_ACK: begin
        elig0 = req0 & win_q;
        elig1 = req1 & ~win_q;
      end
      ST_ACCESS: begin
        if (!we_q) begin
          if (win_q) rdata1_d = ram_out;
          else       rdata0_d = ram_out;
        end
        state_d = ST_ACK;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE || state_q == ST_ACK) begin
      if (elig0 || elig1) begin
        if (elig0 && elig1) grant_sel = FIXED_PRIO ? 1'b0 : ~last_q;
        else                grant_sel = elig1;
        win_d   = grant_sel;
        last_d  = grant_sel;
        we_d    = grant_sel ? we1 : we0;
        addr_d  = grant_sel ? addr1 : addr0;
        wdata_d = grant_sel ? wdata1 : wdata0;
        state_d = ST_ACCESS;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // RAM address/data come straight from the latched command, so they hold
  // their last values outside ACCESS. The write enable is decoded from the
  // state register, which makes it drop as soon as reset is asserted.
  assign busy        = (state_q == ST_ACCESS);
  assign ram_load    = busy & we_q;
  assign ram_address = addr_q;
  assign ram_in      = wdata_q;
  assign ack0        = (state_q == ST_ACK) & ~win_q;
  assign ack1        = (state_q == ST_ACK) & win_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;

endmodule
